ccal_result_scheduler: RTL and testbench

CCAL_RESULT_SCHEDULER -- requirements
Module: ccal_result_scheduler

---
 rtl/ccal_result_scheduler_if.sv | 40 ++++
 rtl/ccal_result_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_ccal_result_scheduler.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccal_result_scheduler_if.sv
// Record scheduler bus: labeling-side inputs, record stream
// and per-frame statistics.
interface ccal_result_scheduler_if #(
  parameter int CW = 16
);
  logic          Vsync;
  logic          DataOutEn;
  logic [31:0]   SumI;
  logic [15:0]   XMaxI;
  logic [15:0]   YMaxI;
  logic [15:0]   XMinI;
  logic [15:0]   YMinI;
  logic [31:0]   MinSum;
  logic          RecValid;
  logic          RecReady;
  logic [95:0]   RecData;
  logic          FrameDone;
  logic [CW-1:0] ShapeCount;
  logic [CW-1:0] FiltCount;
  logic [CW-1:0] DropCount;
  logic          FrameOverrun;

  modport master (
    output Vsync, DataOutEn, SumI,
    output XMaxI, YMaxI, XMinI, YMinI,
    output MinSum, RecReady,
    input  RecValid, RecData, FrameDone,
    input  ShapeCount, FiltCount, DropCount,
    input  FrameOverrun
  );

  modport slave (
    input  Vsync, DataOutEn, SumI,
    input  XMaxI, YMaxI, XMinI, YMinI,
    input  MinSum, RecReady,
    output RecValid, RecData, FrameDone,
    output ShapeCount, FiltCount, DropCount,
    output FrameOverrun
  );
endinterface

// File: rtl/ccal_result_scheduler.sv
// Area-filters labeled shapes into a show-ahead FIFO and
// tracks per-frame drain completion and statistics.
module ccal_result_scheduler #(
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input logic clk,
  input logic rst,
  ccal_result_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } state_t;

  state_t state;
  state_t stateNxt;

  logic          vsyncQ;
  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic [AW:0]   flushLeft;
  logic [AW:0]   flushNxt;
  logic [AW:0]   occAfterRd;

  logic [CW-1:0] shapeCnt;
  logic [CW-1:0] filtCnt;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] shapeBase;
  logic [CW-1:0] filtBase;
  logic [CW-1:0] dropBase;
  logic [CW-1:0] shapeNxt;
  logic [CW-1:0] filtNxt;
  logic [CW-1:0] dropNxt;
  logic [CW-1:0] pubShape;
  logic [CW-1:0] pubFilt;
  logic [CW-1:0] pubDrop;
  logic [CW-1:0] pubShapeNxt;
  logic [CW-1:0] pubFiltNxt;
  logic [CW-1:0] pubDropNxt;

  logic frameDone;
  logic doneNxt;
  logic overrun;
  logic ovrNxt;

  logic boundary;
  logic active;
  logic qual;
  logic full;
  logic empty;
  logic rd;
  logic wr;
  logic incShape;
  logic incFilt;
  logic incDrop;

  function automatic logic [CW-1:0] satInc(
    input logic [CW-1:0] v,
    input logic          inc
  );
    return (inc && v != '1) ? v + 1'b1 : v;
  endfunction

  assign boundary = bus.Vsync & ~vsyncQ;
  assign active   = state != IDLE;
  assign qual     = bus.SumI >= bus.MinSum;
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign rd       = !empty && bus.RecReady;

  // A full FIFO drops the record even if the head leaves now.
  assign incShape = active && bus.DataOutEn
                  && qual && !full;
  assign incFilt  = active && bus.DataOutEn && !qual;
  assign incDrop  = active && bus.DataOutEn
                  && qual && full;
  assign wr       = incShape;

  assign occAfterRd = count - (AW+1)'(rd);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt    = state;
    flushNxt    = flushLeft;
    doneNxt     = 1'b0;
    ovrNxt      = overrun;
    pubShapeNxt = pubShape;
    pubFiltNxt  = pubFilt;
    pubDropNxt  = pubDrop;
    shapeBase   = shapeCnt;
    filtBase    = filtCnt;
    dropBase    = dropCnt;
    unique case (state)
      IDLE: begin
        if (boundary) stateNxt = COLLECT;
      end
      COLLECT, FLUSH: begin
        if (boundary) begin
          if (state == FLUSH) ovrNxt = 1'b1;
          pubShapeNxt = shapeCnt;
          pubFiltNxt  = filtCnt;
          pubDropNxt  = dropCnt;
          shapeBase   = '0;
          filtBase    = '0;
          dropBase    = '0;
          flushNxt    = occAfterRd;
          if (occAfterRd == '0) begin
            doneNxt  = 1'b1;
            stateNxt = COLLECT;
          end else begin
            stateNxt = FLUSH;
          end
        end else if (state == FLUSH && rd) begin
          flushNxt = flushLeft - 1'b1;
          if (flushLeft == (AW+1)'(1)) begin
            doneNxt  = 1'b1;
            stateNxt = COLLECT;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
    shapeNxt = satInc(shapeBase, incShape);
    filtNxt  = satInc(filtBase, incFilt);
    dropNxt  = satInc(dropBase, incDrop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsyncQ    <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      flushLeft <= '0;
      shapeCnt  <= '0;
      filtCnt   <= '0;
      dropCnt   <= '0;
      pubShape  <= '0;
      pubFilt   <= '0;
      pubDrop   <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      vsyncQ    <= bus.Vsync;
      if (wr) wrPtr <= wrPtr + 1'b1;
      if (rd) rdPtr <= rdPtr + 1'b1;
      count     <= count + (AW+1)'(wr)
                 - (AW+1)'(rd);
      flushLeft <= flushNxt;
      shapeCnt  <= shapeNxt;
      filtCnt   <= filtNxt;
      dropCnt   <= dropNxt;
      pubShape  <= pubShapeNxt;
      pubFilt   <= pubFiltNxt;
      pubDrop   <= pubDropNxt;
      frameDone <= doneNxt;
      overrun   <= ovrNxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wrPtr] <= {bus.SumI, bus.XMaxI,
                     bus.YMaxI, bus.XMinI,
                     bus.YMinI};
    end
  end

  assign bus.RecValid     = !empty;
  assign bus.RecData      = empty ? '0 : mem[rdPtr];
  assign bus.FrameDone    = frameDone;
  assign bus.FrameOverrun = overrun;
  assign bus.ShapeCount   = pubShape;
  assign bus.FiltCount    = pubFilt;
  assign bus.DropCount    = pubDrop;
endmodule

// File: tb/tb_ccal_result_scheduler.sv
// Randomized and directed bench for the result scheduler,
// checked against a frame-tagged queue model.
module tb_ccal_result_scheduler;
  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passCnt = 0;
  int   totCnt  = 0;

  always #5 clk = ~clk;

  ccal_result_scheduler_if #(.CW(CW)) bus ();

  ccal_result_scheduler #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model: each queued record carries the frame it belongs to
  logic [95:0]   mq [$];
  int            tq [$];
  bit            mActive;
  bit            mVs;
  bit            pending;
  int            curFrame;
  int            closed;
  logic [CW-1:0] fs, ff, fd;
  logic [CW-1:0] pS, pF, pD;
  logic          mOvr;
  logic          expDone;

  function automatic logic [CW-1:0] sat(
    input logic [CW-1:0] x
  );
    return (x == '1) ? x : x + 1'b1;
  endfunction

  task automatic tick();
    bit          bnd;
    bit          doWr;
    int          n;
    logic [95:0] rec;
    expDone = 1'b0;
    if (rst) begin
      mq.delete();
      tq.delete();
      mActive = 0; mVs = 0; pending = 0;
      curFrame = 0; closed = 0;
      fs = '0; ff = '0; fd = '0;
      pS = '0; pF = '0; pD = '0;
      mOvr = 1'b0;
    end else begin
      bnd  = bus.Vsync && !mVs;
      doWr = 0;
      rec  = {bus.SumI, bus.XMaxI, bus.YMaxI,
              bus.XMinI, bus.YMinI};
      if (mActive && bnd) begin
        if (pending) mOvr = 1'b1;
        pS = fs; pF = ff; pD = fd;
        fs = '0; ff = '0; fd = '0;
        closed = curFrame;
        curFrame++;
        pending = 1;
      end
      if (mActive && bus.DataOutEn) begin
        if (bus.SumI < bus.MinSum) ff = sat(ff);
        else if (mq.size() >= DEPTH) fd = sat(fd);
        else begin
          fs = sat(fs);
          doWr = 1;
        end
      end
      if (mq.size() > 0 && bus.RecReady) begin
        void'(mq.pop_front());
        void'(tq.pop_front());
      end
      if (doWr) begin
        mq.push_back(rec);
        tq.push_back(curFrame);
      end
      if (!mActive && bnd) mActive = 1;
      if (pending) begin
        n = 0;
        foreach (tq[i]) if (tq[i] <= closed) n++;
        if (n == 0) begin
          expDone = 1'b1;
          pending = 0;
        end
      end
      mVs = bus.Vsync;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input int sum);
    bus.DataOutEn = en;
    bus.SumI      = 32'(sum);
    bus.XMaxI     = 16'($urandom);
    bus.YMaxI     = 16'($urandom);
    bus.XMinI     = 16'($urandom);
    bus.YMinI     = 16'($urandom);
  endtask

  task automatic vpulse();
    drive(0, 0);
    bus.Vsync = 1'b1;
    tick();
    bus.Vsync = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(0, 0);
    bus.Vsync = 1'b0;
    bus.RecReady = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.MinSum = 32'd0;
    doReset();
    tick();
    totCnt++;
    if (bus.RecValid !== 1'b0)
      $display("FAIL reset_valid got %0b want 0",
               bus.RecValid);
    else passCnt++;
    totCnt++;
    if (bus.RecData !== 96'd0)
      $display("FAIL reset_data got %h want 0",
               bus.RecData);
    else passCnt++;
    totCnt++;
    if (bus.FrameDone !== 1'b0 ||
        bus.FrameOverrun !== 1'b0)
      $display("FAIL reset_flags got %0b%0b want 00",
               bus.FrameDone, bus.FrameOverrun);
    else passCnt++;
    totCnt++;
    if (bus.ShapeCount !== '0 ||
        bus.FiltCount !== '0 || bus.DropCount !== '0)
      $display("FAIL reset_counts got %0d/%0d/%0d want 0",
               bus.ShapeCount, bus.FiltCount,
               bus.DropCount);
    else passCnt++;
  endtask

  task automatic test_pre_vsync();
    int seen;
    doReset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 100);
      tick();
      if (bus.RecValid) seen++;
    end
    totCnt++;
    if (seen !== 0)
      $display("FAIL idle_ignore got %0d valid want 0",
               seen);
    else passCnt++;
    vpulse();
    tick();
    tick();
    vpulse();
    totCnt++;
    if (bus.ShapeCount !== '0 ||
        bus.FiltCount !== '0 || bus.DropCount !== '0)
      $display("FAIL first_frame got %0d/%0d/%0d want 0",
               bus.ShapeCount, bus.FiltCount,
               bus.DropCount);
    else passCnt++;
    totCnt++;
    if (bus.FrameDone !== 1'b1)
      $display("FAIL empty_done got %0b want 1",
               bus.FrameDone);
    else passCnt++;
  endtask

  task automatic test_filter();
    doReset();
    bus.MinSum = 32'd10;
    vpulse();
    bus.RecReady = 1'b1;
    drive(1, 5);
    tick();
    drive(1, 10);
    tick();
    totCnt++;
    if (bus.RecData[95:64] !== 32'd10)
      $display("FAIL filt_first got %0d want 10",
               bus.RecData[95:64]);
    else passCnt++;
    drive(1, 200);
    tick();
    totCnt++;
    if (bus.RecData[95:64] !== 32'd200)
      $display("FAIL filt_second got %0d want 200",
               bus.RecData[95:64]);
    else passCnt++;
    drive(0, 0);
    tick();
    totCnt++;
    if (bus.RecValid !== 1'b0)
      $display("FAIL filt_drained got %0b want 0",
               bus.RecValid);
    else passCnt++;
    vpulse();
    totCnt++;
    if (bus.ShapeCount !== 4'd2 ||
        bus.FiltCount !== 4'd1 || bus.DropCount !== 4'd0)
      $display("FAIL filt_counts got %0d/%0d/%0d want 2/1/0",
               bus.ShapeCount, bus.FiltCount,
               bus.DropCount);
    else passCnt++;
    totCnt++;
    if (bus.FrameDone !== 1'b1)
      $display("FAIL filt_done got %0b want 1",
               bus.FrameDone);
    else passCnt++;
  endtask

  task automatic test_full_drop();
    int xf, doneAt, pulses;
    doReset();
    bus.MinSum = 32'd0;
    vpulse();
    for (int i = 0; i < 20; i++) begin
      drive(1, i + 1);
      tick();
    end
    drive(0, 0);
    totCnt++;
    if (bus.RecValid !== 1'b1 ||
        bus.RecData[95:64] !== 32'd1)
      $display("FAIL full_head got %0b/%0d want 1/1",
               bus.RecValid, bus.RecData[95:64]);
    else passCnt++;
    vpulse();
    totCnt++;
    if (bus.DropCount !== 4'd4)
      $display("FAIL full_drops got %0d want 4",
               bus.DropCount);
    else passCnt++;
    totCnt++;
    if (bus.ShapeCount !== 4'd15)
      $display("FAIL full_shape_sat got %0d want 15",
               bus.ShapeCount);
    else passCnt++;
    bus.RecReady = 1'b1;
    xf = 0; doneAt = -1; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.RecValid) xf++;
      tick();
      if (bus.FrameDone) begin
        pulses++;
        doneAt = xf;
      end
    end
    totCnt++;
    if (doneAt !== 16 || pulses !== 1)
      $display("FAIL full_done got at %0d x%0d want 16 x1",
               doneAt, pulses);
    else passCnt++;
  endtask

  task automatic test_flush_newframe();
    int xf, doneAt, pulses;
    doReset();
    bus.MinSum = 32'd0;
    vpulse();
    for (int i = 0; i < 3; i++) begin
      drive(1, 50 + i);
      tick();
    end
    vpulse();
    for (int i = 0; i < 2; i++) begin
      drive(1, 70 + i);
      tick();
    end
    drive(0, 0);
    bus.RecReady = 1'b1;
    xf = 0; doneAt = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.RecValid) xf++;
      tick();
      if (bus.FrameDone) begin
        pulses++;
        doneAt = xf;
      end
    end
    totCnt++;
    if (doneAt !== 3 || pulses !== 1)
      $display("FAIL flush_done got at %0d x%0d want 3 x1",
               doneAt, pulses);
    else passCnt++;
    vpulse();
    totCnt++;
    if (bus.ShapeCount !== 4'd2)
      $display("FAIL flush_next got %0d want 2",
               bus.ShapeCount);
    else passCnt++;
  endtask

  task automatic test_overrun();
    int xf, doneAt, pulses;
    doReset();
    bus.MinSum = 32'd0;
    vpulse();
    for (int i = 0; i < 5; i++) begin
      drive(1, 30 + i);
      tick();
    end
    vpulse();
    for (int i = 0; i < 2; i++) begin
      drive(1, 90 + i);
      tick();
    end
    totCnt++;
    if (bus.FrameOverrun !== 1'b0)
      $display("FAIL ovr_early got %0b want 0",
               bus.FrameOverrun);
    else passCnt++;
    vpulse();
    totCnt++;
    if (bus.FrameOverrun !== 1'b1 ||
        bus.FrameDone !== 1'b0)
      $display("FAIL ovr_set got %0b/%0b want 1/0",
               bus.FrameOverrun, bus.FrameDone);
    else passCnt++;
    bus.RecReady = 1'b1;
    xf = 0; doneAt = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.RecValid) xf++;
      tick();
      if (bus.FrameDone) begin
        pulses++;
        doneAt = xf;
      end
    end
    totCnt++;
    if (doneAt !== 7 || pulses !== 1)
      $display("FAIL ovr_done got at %0d x%0d want 7 x1",
               doneAt, pulses);
    else passCnt++;
  endtask

  task automatic test_reset_midstream();
    int seen;
    bus.RecReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 40 + i);
      tick();
    end
    drive(0, 0);
    totCnt++;
    if (bus.RecValid !== 1'b1 ||
        bus.FrameOverrun !== 1'b1)
      $display("FAIL mid_pre got %0b/%0b want 1/1",
               bus.RecValid, bus.FrameOverrun);
    else passCnt++;
    bus.RecReady = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    totCnt++;
    if (bus.RecValid !== 1'b0 ||
        bus.RecData !== 96'd0)
      $display("FAIL mid_fifo got %0b/%h want 0/0",
               bus.RecValid, bus.RecData);
    else passCnt++;
    totCnt++;
    if (bus.FrameOverrun !== 1'b0 ||
        bus.FrameDone !== 1'b0 ||
        bus.ShapeCount !== '0 ||
        bus.FiltCount !== '0 || bus.DropCount !== '0)
      $display("FAIL mid_outs got %0b/%0b/%0d/%0d/%0d want 0",
               bus.FrameOverrun, bus.FrameDone,
               bus.ShapeCount, bus.FiltCount,
               bus.DropCount);
    else passCnt++;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 100);
      tick();
      if (bus.RecValid) seen++;
    end
    drive(0, 0);
    totCnt++;
    if (seen !== 0)
      $display("FAIL mid_idle got %0d valid want 0", seen);
    else passCnt++;
  endtask

  task automatic test_random();
    int pct;
    logic [95:0] expData;
    doReset();
    pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pct = $urandom_range(5, 95);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 24) == 0)
        bus.Vsync = ~bus.Vsync;
      bus.MinSum = 32'($urandom_range(0, 30));
      drive($urandom_range(0, 99) < 45,
            $urandom_range(0, 40));
      bus.RecReady = $urandom_range(0, 99) < pct;
      tick();
      expData = (mq.size() > 0) ? mq[0] : 96'd0;
      totCnt++;
      if (bus.RecValid !== 1'(mq.size() != 0))
        $display("FAIL rnd_valid c%0d got %0b want %0b",
                 c, bus.RecValid, mq.size() != 0);
      else passCnt++;
      totCnt++;
      if (bus.RecData !== expData)
        $display("FAIL rnd_data c%0d got %h want %h",
                 c, bus.RecData, expData);
      else passCnt++;
      totCnt++;
      if (bus.FrameDone !== expDone)
        $display("FAIL rnd_done c%0d got %0b want %0b",
                 c, bus.FrameDone, expDone);
      else passCnt++;
      totCnt++;
      if (bus.FrameOverrun !== mOvr)
        $display("FAIL rnd_ovr c%0d got %0b want %0b",
                 c, bus.FrameOverrun, mOvr);
      else passCnt++;
      totCnt++;
      if (bus.ShapeCount !== pS ||
          bus.FiltCount !== pF || bus.DropCount !== pD)
        $display("FAIL rnd_cnt c%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 c, bus.ShapeCount, bus.FiltCount,
                 bus.DropCount, pS, pF, pD);
      else passCnt++;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.Vsync     = 1'b0;
    bus.RecReady  = 1'b0;
    bus.MinSum    = 32'd0;
    drive(0, 0);
    test_reset();
    test_pre_vsync();
    test_filter();
    test_full_drop();
    test_flush_newframe();
    test_overrun();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end
endmodule
